mem_stage: RTL and testbench
============================

# mem_stage

Pipeline MEM stage for the five-stage MIPS datapath: owns the word-addressed data memory and the MEM/WB pipeline register. It consumes the store-data forwarding select `forwardM` produced by the memory forwarding unit, choosing between the EX/MEM store operand and the value currently held in MEM/WB. Loads and ALU results are registered into MEM/WB for the write-back stage. A sticky error flag and a committed-store counter support verification.

## Interface
- `ADDR_WIDTH`, 8, word-index width; memory holds 2^ADDR_WIDTH 32-bit words.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold MEM/WB, suppress store, counter and error updates.
- `EXMEM_MemWrite`  in  1  store instruction in MEM.
- `EXMEM_MemRead`  in  1  load instruction in MEM.
- `EXMEM_RegWrite`  in  1  instruction writes a register.
- `EXMEM_MemtoReg`  in  1  write-back source is memory, not ALU.
- `EXMEM_ALUResult`  in  32  effective byte address or ALU result.
- `EXMEM_WriteData`  in  32  store operand (rt value from EX).
- `EXMEM_RegisterRd`  in  5  destination register.
- `forwardM`  in  1  1 = store MEM/WB write-back value instead of `EXMEM_WriteData`.
- `MEMWB_RegWrite`  out  1  registered RegWrite.
- `MEMWB_RegisterRd`  out  5  registered destination.
- `MEMWB_WriteData`  out  32  registered write-back value.
- `mem_err`  out  1  sticky misaligned/out-of-range access flag.
- `store_count`  out  16  number of committed stores.

## Operation
- Access valid iff `EXMEM_ALUResult[1:0]==0` and `EXMEM_ALUResult[31:ADDR_WIDTH+2]==0`; word index = `EXMEM_ALUResult[ADDR_WIDTH+1:2]`.
- Store data = `forwardM ? MEMWB_WriteData : EXMEM_WriteData`.
- Store commits at rising edge when `EXMEM_MemWrite && !EXMEM_MemRead && valid && !stall`; `store_count` increments by 1, wraps 16'hFFFF -> 0.
- Read data: combinational from array at word index; 32'h0 when access invalid.
- Write-back value = `EXMEM_MemtoReg ? read data : EXMEM_ALUResult`.
- MEM/WB capture when `!stall`: RegWrite, RegisterRd, write-back value. With `stall`: all three hold.
- `mem_err` set (when `!stall`) if (MemRead or MemWrite) and access invalid, or MemRead and MemWrite both 1; never cleared except by reset. Both-asserted case: no store, MEM/WB captures as for ALU path with RegWrite as given.
- `forwardM` ignored when `EXMEM_MemWrite=0`.

## Timing
- Reset (`rst_n` low, asynchronous): MEMWB_RegWrite=0, MEMWB_RegisterRd=0, MEMWB_WriteData=0, mem_err=0, store_count=0, all memory words = 0. Reset mid-store: store discarded.
- Load latency: data visible on `MEMWB_WriteData` one cycle after instruction is in MEM.
- Store visible to a load in the following cycle (write at edge N, load in cycle N+1 reads new value). Load and store never share a cycle (single instruction per stage).
- Forwarded value is `MEMWB_WriteData` as held during the store cycle, i.e. the result of the immediately preceding instruction.
- Stall deasserts: stage resumes with the same EX/MEM inputs; store commits exactly once.

## Test plan
- Reset then ALU op (ALUResult=32'h1234, MemtoReg=0, RegWrite=1, Rd=5) -> next cycle MEMWB_WriteData=32'h1234, Rd=5, RegWrite=1; store_count=0.
- Store 32'hDEADBEEF to addr 32'h10, forwardM=0; next cycle load addr 32'h10, MemtoReg=1 -> MEMWB_WriteData=32'hDEADBEEF; store_count=1.
- Load Rd=8 from addr 0x10 (DEADBEEF), next cycle store addr 0x14 with EXMEM_WriteData=0, forwardM=1 -> load 0x14 returns 32'hDEADBEEF.
- Store addr 32'h13 (misaligned) and separately addr 32'h400 (out of range, ADDR_WIDTH=8) -> no memory change, store_count unchanged, mem_err=1 and stays 1.
- Store with stall=1 for 3 cycles, then stall=0 -> single commit, store_count +1, MEM/WB outputs held during stall.
- Assert rst_n low mid-sequence after 2 stores -> all outputs 0 immediately, loads of prior addresses return 0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: word-addressed data memory, store-data forwarding and the MEM/WB register.
// Also keeps a sticky access-error flag and a committed-store counter.
module mem_stage #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        EXMEM_MemWrite,
    input  logic        EXMEM_MemRead,
    input  logic        EXMEM_RegWrite,
    input  logic        EXMEM_MemtoReg,
    input  logic [31:0] EXMEM_ALUResult,
    input  logic [31:0] EXMEM_WriteData,
    input  logic [4:0]  EXMEM_RegisterRd,
    input  logic        forwardM,
    output logic        MEMWB_RegWrite,
    output logic [4:0]  MEMWB_RegisterRd,
    output logic [31:0] MEMWB_WriteData,
    output logic        mem_err,
    output logic [15:0] store_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  addr_ok;
    logic                  do_store;
    logic                  err_now;
    logic [31:0]           store_data;
    logic [31:0]           read_data;
    logic [31:0]           wb_value;

    assign word_idx = EXMEM_ALUResult[ADDR_WIDTH+1:2];
    assign addr_ok  = (EXMEM_ALUResult[1:0] == 2'b00) &&
                      (EXMEM_ALUResult[31:ADDR_WIDTH+2] == '0);

    // Forwarded operand is the MEM/WB value held during the store cycle.
    assign store_data = forwardM ? MEMWB_WriteData : EXMEM_WriteData;
    assign read_data  = addr_ok ? mem[word_idx] : 32'h0;
    assign wb_value   = EXMEM_MemtoReg ? read_data : EXMEM_ALUResult;

    // A simultaneous read+write request is treated as an error and never stores.
    assign do_store = EXMEM_MemWrite && !EXMEM_MemRead && addr_ok && !stall;
    assign err_now  = ((EXMEM_MemRead || EXMEM_MemWrite) && !addr_ok) ||
                      (EXMEM_MemRead && EXMEM_MemWrite);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (do_store) begin
            mem[word_idx] <= store_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MEMWB_RegWrite   <= 1'b0;
            MEMWB_RegisterRd <= 5'd0;
            MEMWB_WriteData  <= 32'h0;
        end else if (!stall) begin
            MEMWB_RegWrite   <= EXMEM_RegWrite;
            MEMWB_RegisterRd <= EXMEM_RegisterRd;
            MEMWB_WriteData  <= wb_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err     <= 1'b0;
            store_count <= 16'd0;
        end else begin
            if (!stall && err_now) mem_err <= 1'b1;
            if (do_store) store_count <= store_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios then random traffic
// compared against an array-based reference model of the stage.
module tb_mem_stage;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        mw, mr, rw, mtr, fwd;
    logic [31:0] alu, wd;
    logic [4:0]  rd;
    logic        o_rw;
    logic [4:0]  o_rd;
    logic [31:0] o_wb;
    logic        o_err;
    logic [15:0] o_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_mem [DEPTH];
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_wb;
    logic        m_err;
    logic [15:0] m_cnt;

    mem_stage #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .EXMEM_MemWrite(mw), .EXMEM_MemRead(mr), .EXMEM_RegWrite(rw),
        .EXMEM_MemtoReg(mtr), .EXMEM_ALUResult(alu), .EXMEM_WriteData(wd),
        .EXMEM_RegisterRd(rd), .forwardM(fwd),
        .MEMWB_RegWrite(o_rw), .MEMWB_RegisterRd(o_rd), .MEMWB_WriteData(o_wb),
        .mem_err(o_err), .store_count(o_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".regwrite"}, 32'(o_rw), 32'(m_rw));
        check({tag, ".rd"},       32'(o_rd), 32'(m_rd));
        check({tag, ".wb"},       o_wb,      m_wb);
        check({tag, ".err"},      32'(o_err), 32'(m_err));
        check({tag, ".count"},    32'(o_cnt), 32'(m_cnt));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_rw = 1'b0; m_rd = 5'd0; m_wb = 32'h0; m_err = 1'b0; m_cnt = 16'd0;
    endtask

    // One rising edge of the stage, computed from the currently driven inputs.
    task automatic model_edge();
        bit          valid;
        int          idx;
        logic [31:0] rdata;
        valid = (alu % 4 == 0) && (alu < 32'(4 * DEPTH));
        idx   = valid ? int'(alu / 4) : 0;
        if (!stall) begin
            rdata = valid ? m_mem[idx] : 32'h0;
            if (((mr || mw) && !valid) || (mr && mw)) m_err = 1'b1;
            if (mw && !mr && valid) begin
                m_mem[idx] = fwd ? m_wb : wd;
                m_cnt      = m_cnt + 16'd1;
            end
            m_rw = rw;
            m_rd = rd;
            m_wb = mtr ? rdata : alu;
        end
    endtask

    task automatic set_op(input logic i_mw, input logic i_mr, input logic i_rw, input logic i_mtr,
                          input logic [31:0] i_alu, input logic [31:0] i_wd,
                          input logic [4:0] i_rd, input logic i_fwd);
        mw = i_mw; mr = i_mr; rw = i_rw; mtr = i_mtr;
        alu = i_alu; wd = i_wd; rd = i_rd; fwd = i_fwd;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0);
        model_reset();
        #22;
        check_all("reset");
        rst_n = 1'b1;

        // ALU result path
        set_op(0, 0, 1, 0, 32'h1234, 32'h0, 5'd5, 0);
        cycle("alu");
        check("alu.const", o_wb, 32'h1234);

        // store then load same word
        set_op(1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0);
        cycle("st10");
        set_op(0, 1, 1, 1, 32'h10, 32'h0, 5'd7, 0);
        cycle("ld10");
        check("ld10.const", o_wb, 32'hDEADBEEF);
        check("ld10.cnt", 32'(o_cnt), 32'd1);

        // load followed by forwarded store
        set_op(0, 1, 1, 1, 32'h10, 32'h0, 5'd8, 0);
        cycle("ld8");
        set_op(1, 0, 0, 0, 32'h14, 32'h0, 5'd0, 1);
        cycle("st14fwd");
        set_op(0, 1, 1, 1, 32'h14, 32'h0, 5'd9, 0);
        cycle("ld14");
        check("fwd.const", o_wb, 32'hDEADBEEF);

        // misaligned and out-of-range stores
        set_op(1, 0, 0, 0, 32'h13, 32'h55, 5'd0, 0);
        cycle("st_mis");
        check("mis.err", 32'(o_err), 32'd1);
        set_op(1, 0, 0, 0, 32'h400, 32'h66, 5'd0, 0);
        cycle("st_oor");
        set_op(0, 0, 1, 0, 32'h77, 32'h0, 5'd3, 0);
        cycle("alu_after_err");
        check("err.sticky", 32'(o_err), 32'd1);
        check("err.cnt", 32'(o_cnt), 32'd2);
        set_op(0, 1, 1, 1, 32'h0, 32'h0, 5'd4, 0);
        cycle("ld0");

        // stalled store commits once
        set_op(1, 0, 0, 0, 32'h20, 32'hCAFEF00D, 5'd0, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle("st_stall");
        check("stall.hold", o_wb, 32'h0);
        stall = 1'b0;
        cycle("st_resume");
        set_op(0, 1, 1, 1, 32'h20, 32'h0, 5'd6, 0);
        cycle("ld20");
        check("stall.const", o_wb, 32'hCAFEF00D);
        check("stall.cnt", 32'(o_cnt), 32'd3);

        // asynchronous reset after two more stores
        set_op(1, 0, 0, 0, 32'h24, 32'h11111111, 5'd0, 0);
        cycle("st24");
        set_op(1, 0, 0, 0, 32'h28, 32'h22222222, 5'd0, 0);
        cycle("st28");
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst.cnt", 32'(o_cnt), 32'd0);
        #1 rst_n = 1'b1;
        set_op(0, 1, 1, 1, 32'h24, 32'h0, 5'd1, 0);
        cycle("ld24_rst");
        check("rst.mem24", o_wb, 32'h0);
        set_op(0, 1, 1, 1, 32'h10, 32'h0, 5'd2, 0);
        cycle("ld10_rst");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int          kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 19));
            a    = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 11) == 0)
                a = ($urandom_range(0, 1) == 0) ? (a | 32'($urandom_range(1, 3)))
                                                 : (a + 32'h400 * 32'($urandom_range(1, 8)));
            stall = ($urandom_range(0, 4) == 0);
            if (kind < 6)
                set_op(0, 0, 1'($urandom), 0, $urandom, $urandom, 5'($urandom), 1'($urandom));
            else if (kind < 12)
                set_op(0, 1, 1, 1, a, $urandom, 5'($urandom), 1'($urandom));
            else if (kind < 19)
                set_op(1, 0, 0, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom));
            else
                set_op(1, 1, 1'($urandom), 0, a, $urandom, 5'($urandom), 1'($urandom));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
